// File: rtl/rat_pkg.sv
// Shared types and helpers for the register alias table (rat_multi / rat_regfile).
package rat_pkg;

  localparam int DEF_NREGS    = 32;
  localparam int DEF_XLEN     = 32;
  localparam int DEF_ROB_W    = 7;
  localparam int DEF_RENAME_W = 2;
  localparam int DEF_COPY_W   = 4;

  typedef enum logic {
    IDLE,
    RECOVER
  } state_e;

  typedef logic [DEF_ROB_W-1:0] tag_t;

  typedef struct packed {
    logic                valid;
    logic [DEF_XLEN-1:0] value;
    tag_t                tag;
  } entry_t;

  // Address width for an n-entry table; never narrower than one bit.
  function automatic int areg_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rat_regfile.sv
// NREGS x W storage with NRD asynchronous read ports and NWR write ports;
// on an address collision the highest-numbered write port wins.
module rat_regfile
  import rat_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int W     = DEF_XLEN,
  parameter int NRD   = 2 * DEF_RENAME_W,
  parameter int NWR   = DEF_COPY_W + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NRD*areg_w(NREGS)-1:0]  rd_addr,
  output logic [NRD*W-1:0]              rd_data,
  input  logic [NWR-1:0]                wr_en,
  input  logic [NWR*areg_w(NREGS)-1:0]  wr_addr,
  input  logic [NWR*W-1:0]              wr_data
);

  localparam int AW = areg_w(NREGS);

  logic [W-1:0] mem [NREGS];

  // NOTE: the array is reset because the table's reset contents (all zero)
  // are architecturally visible; NBAs let later ports override earlier ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p]) mem[wr_addr[p*AW +: AW]] <= wr_data[p*W +: W];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NRD; r++) rd_data[r*W +: W] = mem[rd_addr[r*AW +: AW]];
  end

endmodule

// File: rtl/rat_multi.sv
// Multi-lane register alias table with tag-checked writeback and multi-cycle recovery.
// Optional macro RAT_WB_FWD_EN folds a same-cycle matching writeback into the lookup result.
module rat_multi
  import rat_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int XLEN     = DEF_XLEN,
  parameter int ROB_W    = DEF_ROB_W,
  parameter int RENAME_W = DEF_RENAME_W,
  parameter int COPY_W   = DEF_COPY_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [RENAME_W-1:0]                   rename_rat_valid,
  input  logic [RENAME_W*(areg_w(NREGS)+1)-1:0] rename_rat_rd,
  input  logic [RENAME_W*ROB_W-1:0]             rename_rat_robid,
  input  logic [RENAME_W*areg_w(NREGS)-1:0]     rename_rat_rs1,
  input  logic [RENAME_W*areg_w(NREGS)-1:0]     rename_rat_rs2,
  output logic [RENAME_W-1:0]                   rat_rs1_valid,
  output logic [RENAME_W*XLEN-1:0]              rat_rs1_tagval,
  output logic [RENAME_W-1:0]                   rat_rs2_valid,
  output logic [RENAME_W*XLEN-1:0]              rat_rs2_tagval,
  output logic                                  rat_ready,
  input  logic                                  wb_valid,
  input  logic                                  wb_error,
  input  logic [ROB_W-1:0]                      wb_robid,
  input  logic [areg_w(NREGS):0]                wb_rd,
  input  logic [XLEN-1:0]                       wb_result,
  input  logic                                  rob_flush,
  input  logic                                  rob_ret_valid,
  input  logic [areg_w(NREGS):0]                rob_ret_rd,
  input  logic [XLEN-1:0]                       rob_ret_result
);

  localparam int AREG_W = areg_w(NREGS);
  localparam int NSRC   = 2 * RENAME_W;
  localparam int NCOPY  = NREGS / COPY_W;
  localparam int CNT_W  = areg_w(NCOPY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCOPY - 1);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tagval;
  } lookup_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREGS-1:0]  valid_q, valid_d;
  logic              recovering;

  assign recovering = (state_q == RECOVER);
  assign rat_ready  = ~recovering;

  // ---------------- rename lane decode ----------------
  logic [AREG_W-1:0] ren_rd  [RENAME_W];
  logic [ROB_W-1:0]  ren_tag [RENAME_W];
  logic [RENAME_W-1:0] ren_live, ren_wr;

  for (genvar i = 0; i < RENAME_W; i++) begin : g_lane
    assign ren_rd[i]   = rename_rat_rd[i*(AREG_W+1) +: AREG_W];
    assign ren_tag[i]  = rename_rat_robid[i*ROB_W +: ROB_W];
    assign ren_live[i] = rename_rat_valid[i] & rat_ready
                       & ~rename_rat_rd[i*(AREG_W+1) + AREG_W] & (ren_rd[i] != '0);
    assign ren_wr[i]   = ren_live[i] & ~rob_flush;
  end

  // Sources ordered rs1 lanes first, then rs2 lanes.
  logic [NSRC*AREG_W-1:0] src_addr;
  assign src_addr = {rename_rat_rs2, rename_rat_rs1};

  // ---------------- storage ----------------
  logic [NSRC*XLEN-1:0]      spec_rdata;
  logic [(NSRC+1)*ROB_W-1:0] tag_rdata;
  logic [COPY_W*XLEN-1:0]    comm_rdata;
  logic [COPY_W*AREG_W-1:0]  copy_addr;

  for (genvar k = 0; k < COPY_W; k++) begin : g_copy
    assign copy_addr[k*AREG_W +: AREG_W] = AREG_W'(int'(cnt_q) * COPY_W + k);
  end

  logic [AREG_W-1:0] wb_idx, ret_idx;
  logic [ROB_W-1:0]  wb_tag;
  logic              wb_fire, wb_clobber, wb_upd, ret_en;

  assign wb_idx  = wb_rd[AREG_W-1:0];
  assign ret_idx = rob_ret_rd[AREG_W-1:0];
  assign wb_tag  = tag_rdata[NSRC*ROB_W +: ROB_W];

  // Writeback only lands on a still-pending entry whose current tag matches.
  assign wb_fire = wb_valid & ~wb_error & ~wb_rd[AREG_W] & (wb_idx != '0)
                 & rat_ready & ~rob_flush & ~valid_q[wb_idx] & (wb_tag == wb_robid);

  always_comb begin
    wb_clobber = 1'b0;
    for (int i = 0; i < RENAME_W; i++) begin
      if (ren_wr[i] && ren_rd[i] == wb_idx) wb_clobber = 1'b1;
    end
  end

  assign wb_upd = wb_fire & ~wb_clobber;
  assign ret_en = rob_ret_valid & ~rob_ret_rd[AREG_W] & (ret_idx != '0) & rat_ready;

  rat_regfile #(.NREGS(NREGS), .W(XLEN), .NRD(NSRC), .NWR(COPY_W + 1)) u_spec (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (src_addr),
    .rd_data (spec_rdata),
    .wr_en   ({wb_upd, {COPY_W{recovering}}}),
    .wr_addr ({wb_idx, copy_addr}),
    .wr_data ({wb_result, comm_rdata})
  );

  rat_regfile #(.NREGS(NREGS), .W(XLEN), .NRD(COPY_W), .NWR(1)) u_comm (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (copy_addr),
    .rd_data (comm_rdata),
    .wr_en   (ret_en),
    .wr_addr (ret_idx),
    .wr_data (rob_ret_result)
  );

  rat_regfile #(.NREGS(NREGS), .W(ROB_W), .NRD(NSRC + 1), .NWR(RENAME_W)) u_tag (
    .clk     (clk),
    .rst     (rst),
    .rd_addr ({wb_idx, src_addr}),
    .rd_data (tag_rdata),
    .wr_en   (ren_wr),
    .wr_addr ({<<AREG_W{ {<<AREG_W{rename_rat_rd_idx()}} }}),
    .wr_data (rename_rat_robid)
  );

  function automatic logic [RENAME_W*AREG_W-1:0] rename_rat_rd_idx();
    logic [RENAME_W*AREG_W-1:0] r;
    r = '0;
    for (int i = 0; i < RENAME_W; i++) r[i*AREG_W +: AREG_W] = ren_rd[i];
    return r;
  endfunction

  // ---------------- valid bits ----------------
  // NOTE: every combinational output gets a default before any conditional
  // update so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    valid_d = valid_q;
    if (recovering) begin
      for (int k = 0; k < COPY_W; k++) valid_d[copy_addr[k*AREG_W +: AREG_W]] = 1'b1;
    end else begin
      if (wb_upd) valid_d[wb_idx] = 1'b1;
      for (int i = 0; i < RENAME_W; i++) begin
        if (ren_wr[i]) valid_d[ren_rd[i]] = 1'b0;
      end
    end
    valid_d[0] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '1;
    else      valid_q <= valid_d;
  end

  // ---------------- recovery FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rob_flush) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end
      end
      RECOVER: begin
        if (rob_flush) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- lookup ----------------
  for (genvar s = 0; s < NSRC; s++) begin : g_src
    localparam int LANE = s % RENAME_W;
    logic [AREG_W-1:0] a;
    lookup_t lk_d, lk_q;

    assign a = src_addr[s*AREG_W +: AREG_W];

    always_comb begin
      lk_d.valid  = valid_q[a];
      lk_d.tagval = valid_q[a] ? spec_rdata[s*XLEN +: XLEN]
                               : XLEN'(tag_rdata[s*ROB_W +: ROB_W]);
`ifdef RAT_WB_FWD_EN
      if (wb_fire && wb_idx == a) begin
        lk_d.valid  = 1'b1;
        lk_d.tagval = wb_result;
      end
`endif
      // Older lanes in the same group override the table; highest lane last.
      for (int i = 0; i < LANE; i++) begin
        if (ren_live[i] && ren_rd[i] == a) begin
          lk_d.valid  = 1'b0;
          lk_d.tagval = XLEN'(ren_tag[i]);
        end
      end
      if (a == '0) begin
        lk_d.valid  = 1'b1;
        lk_d.tagval = '0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lk_q.valid  <= 1'b1;
        lk_q.tagval <= '0;
      end else begin
        lk_q <= lk_d;
      end
    end

    if (s < RENAME_W) begin : g_rs1
      assign rat_rs1_valid[s]               = lk_q.valid;
      assign rat_rs1_tagval[s*XLEN +: XLEN] = lk_q.tagval;
    end else begin : g_rs2
      assign rat_rs2_valid[s-RENAME_W]               = lk_q.valid;
      assign rat_rs2_tagval[(s-RENAME_W)*XLEN +: XLEN] = lk_q.tagval;
    end
  end

  rename_while_busy : assert property (@(posedge clk) disable iff (!rst)
    !((|rename_rat_valid) && !rat_ready));

endmodule

// File: tb/tb_rat_multi.sv
// Directed self-checking bench for rat_multi at default parameters.
module tb_rat_multi;

  localparam int AW = 5;
  localparam int XL = 32;
  localparam int RW = 7;

  logic          clk;
  logic          rst;
  logic [1:0]    rename_rat_valid;
  logic [11:0]   rename_rat_rd;
  logic [13:0]   rename_rat_robid;
  logic [9:0]    rename_rat_rs1;
  logic [9:0]    rename_rat_rs2;
  logic [1:0]    rat_rs1_valid;
  logic [63:0]   rat_rs1_tagval;
  logic [1:0]    rat_rs2_valid;
  logic [63:0]   rat_rs2_tagval;
  logic          rat_ready;
  logic          wb_valid;
  logic          wb_error;
  logic [6:0]    wb_robid;
  logic [5:0]    wb_rd;
  logic [31:0]   wb_result;
  logic          rob_flush;
  logic          rob_ret_valid;
  logic [5:0]    rob_ret_rd;
  logic [31:0]   rob_ret_result;

  int n_run  = 0;
  int n_fail = 0;

  rat_multi dut (
    .clk              (clk),
    .rst              (rst),
    .rename_rat_valid (rename_rat_valid),
    .rename_rat_rd    (rename_rat_rd),
    .rename_rat_robid (rename_rat_robid),
    .rename_rat_rs1   (rename_rat_rs1),
    .rename_rat_rs2   (rename_rat_rs2),
    .rat_rs1_valid    (rat_rs1_valid),
    .rat_rs1_tagval   (rat_rs1_tagval),
    .rat_rs2_valid    (rat_rs2_valid),
    .rat_rs2_tagval   (rat_rs2_tagval),
    .rat_ready        (rat_ready),
    .wb_valid         (wb_valid),
    .wb_error         (wb_error),
    .wb_robid         (wb_robid),
    .wb_rd            (wb_rd),
    .wb_result        (wb_result),
    .rob_flush        (rob_flush),
    .rob_ret_valid    (rob_ret_valid),
    .rob_ret_rd       (rob_ret_rd),
    .rob_ret_result   (rob_ret_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rename_rat_valid = '0;
    rename_rat_rd    = '0;
    rename_rat_robid = '0;
    rename_rat_rs1   = '0;
    rename_rat_rs2   = '0;
    wb_valid         = 1'b0;
    wb_error         = 1'b0;
    wb_robid         = '0;
    wb_rd            = '0;
    wb_result        = '0;
    rob_flush        = 1'b0;
    rob_ret_valid    = 1'b0;
    rob_ret_rd       = '0;
    rob_ret_result   = '0;
  endtask

  task automatic ren(input int lane, input int rd, input int tag);
    rename_rat_valid[lane]          = 1'b1;
    rename_rat_rd[lane*6 +: 6]      = 6'(rd);
    rename_rat_robid[lane*RW +: RW] = 7'(tag);
  endtask

  task automatic src(input int lane, input int a1, input int a2);
    rename_rat_rs1[lane*AW +: AW] = 5'(a1);
    rename_rat_rs2[lane*AW +: AW] = 5'(a2);
  endtask

  task automatic wb(input int rd, input int tag, input logic [31:0] res);
    wb_valid  = 1'b1;
    wb_rd     = 6'(rd);
    wb_robid  = 7'(tag);
    wb_result = res;
  endtask

  function automatic logic [32:0] rs1(input int lane);
    return {rat_rs1_valid[lane], rat_rs1_tagval[lane*XL +: XL]};
  endfunction

  function automatic logic [32:0] rs2(input int lane);
    return {rat_rs2_valid[lane], rat_rs2_tagval[lane*XL +: XL]};
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    n_run++;
    if ({rat_ready, rat_rs1_valid, rat_rs2_valid} !== 5'b11111) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 11111", {rat_ready, rat_rs1_valid, rat_rs2_valid});
    end
    n_run++;
    if ({rat_rs1_tagval, rat_rs2_tagval} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_tagval: got %h %h want 0", rat_rs1_tagval, rat_rs2_tagval);
    end
    rst = 1'b1;
    src(0, 5, 0);
    tick();
    n_run++;
    if (rs1(0) !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL lookup_r5: got %h want 100000000", rs1(0));
    end
  endtask

  task automatic test_rename_bypass();
    clr();
    ren(0, 3, 'h12);
    src(0, 3, 0);
    src(1, 3, 0);
    tick();
    n_run++;
    if (rs1(1) !== {1'b0, 32'h12}) begin
      n_fail++;
      $display("FAIL bypass_lane1: got %h want 000000012", rs1(1));
    end
    n_run++;
    if (rs1(0) !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL no_self_bypass: got %h want 100000000", rs1(0));
    end
    clr();
    src(0, 3, 3);
    tick();
    n_run++;
    if ({rs1(0), rs2(0)} !== {1'b0, 32'h12, 1'b0, 32'h12}) begin
      n_fail++;
      $display("FAIL table_r3_pending: got %h %h want 000000012", rs1(0), rs2(0));
    end
  endtask

  task automatic test_wb_fwd();
    logic [32:0] exp;
`ifdef RAT_WB_FWD_EN
    exp = {1'b1, 32'hDEAD};
`else
    exp = {1'b0, 32'h12};
`endif
    clr();
    src(0, 3, 0);
    wb(3, 'h12, 32'hDEAD);
    tick();
    n_run++;
    if (rs1(0) !== exp) begin
      n_fail++;
      $display("FAIL wb_same_cycle: got %h want %h", rs1(0), exp);
    end
    clr();
    src(0, 3, 0);
    tick();
    n_run++;
    if (rs1(0) !== {1'b1, 32'hDEAD}) begin
      n_fail++;
      $display("FAIL wb_r3_value: got %h want 10000dead", rs1(0));
    end
    clr();
    wb(3, 'h11, 32'hBEEF);
    tick();
    clr();
    src(0, 3, 0);
    tick();
    n_run++;
    if (rs1(0) !== {1'b1, 32'hDEAD}) begin
      n_fail++;
      $display("FAIL wb_stale_ignored: got %h want 10000dead", rs1(0));
    end
    clr();
    ren(0, 6, 'h30);
    tick();
    clr();
    wb(6, 'h30, 32'h1234);
    wb_error = 1'b1;
    tick();
    clr();
    src(0, 6, 0);
    tick();
    n_run++;
    if (rs1(0) !== {1'b0, 32'h30}) begin
      n_fail++;
      $display("FAIL wb_error_ignored: got %h want 000000030", rs1(0));
    end
  endtask

  task automatic test_same_rd();
    clr();
    ren(0, 4, 'h20);
    ren(1, 4, 'h21);
    tick();
    clr();
    wb(4, 'h20, 32'hAAAA);
    tick();
    clr();
    src(1, 4, 4);
    tick();
    n_run++;
    if ({rs1(1), rs2(1)} !== {1'b0, 32'h21, 1'b0, 32'h21}) begin
      n_fail++;
      $display("FAIL same_rd_high_lane: got %h %h want 000000021", rs1(1), rs2(1));
    end
    clr();
    wb(4, 'h21, 32'h77);
    tick();
    clr();
    src(0, 4, 0);
    tick();
    n_run++;
    if (rs1(0) !== {1'b1, 32'h77}) begin
      n_fail++;
      $display("FAIL same_rd_wb: got %h want 100000077", rs1(0));
    end
  endtask

  task automatic test_x0();
    clr();
    ren(0, 0, 'h05);
    src(1, 0, 0);
    tick();
    n_run++;
    if (rs1(1) !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL x0_no_bypass: got %h want 100000000", rs1(1));
    end
    clr();
    src(0, 0, 0);
    tick();
    n_run++;
    if (rs1(0) !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL x0_table: got %h want 100000000", rs1(0));
    end
  endtask

  task automatic test_back_to_back();
    clr();
    ren(0, 9, 'h40);
    ren(1, 34, 'h33);
    tick();
    clr();
    ren(0, 9, 'h41);
    wb(9, 'h40, 32'hCAFE);
    src(1, 0, 9);
    tick();
    n_run++;
    if (rs2(1) !== {1'b0, 32'h41}) begin
      n_fail++;
      $display("FAIL b2b_bypass: got %h want 000000041", rs2(1));
    end
    clr();
    src(0, 9, 2);
    tick();
    n_run++;
    if (rs1(0) !== {1'b0, 32'h41}) begin
      n_fail++;
      $display("FAIL rename_beats_wb: got %h want 000000041", rs1(0));
    end
    n_run++;
    if (rs2(0) !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL no_dest_lane: got %h want 100000000", rs2(0));
    end
  endtask

  task automatic test_recovery();
    int n;
    clr();
    ren(0, 7, 'h50);
    tick();
    clr();
    rob_flush      = 1'b1;
    rob_ret_valid  = 1'b1;
    rob_ret_rd     = 6'd7;
    rob_ret_result = 32'h55;
    ren(0, 8, 'h70);
    tick();
    clr();
    n = 0;
    while (rat_ready === 1'b0 && n < 20) begin
      n++;
      tick();
    end
    n_run++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL recover_len: got %0d cycles want 8", n);
    end
    src(0, 7, 6);
    src(1, 3, 8);
    tick();
    n_run++;
    if (rs1(0) !== {1'b1, 32'h55}) begin
      n_fail++;
      $display("FAIL recover_r7: got %h want 100000055", rs1(0));
    end
    n_run++;
    if ({rs2(0), rs1(1), rs2(1)} !== {3{1'b1, 32'h0}}) begin
      n_fail++;
      $display("FAIL recover_r6_r3_r8: got %h %h %h want 100000000", rs2(0), rs1(1), rs2(1));
    end
  endtask

  task automatic test_flush_restart();
    int n;
    clr();
    rob_flush = 1'b1;
    tick();
    clr();
    tick();
    tick();
    n_run++;
    if (rat_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_low_mid: got %b want 0", rat_ready);
    end
    rob_flush      = 1'b1;
    rob_ret_valid  = 1'b1;
    rob_ret_rd     = 6'd11;
    rob_ret_result = 32'h99;
    tick();
    clr();
    n = 0;
    while (rat_ready === 1'b0 && n < 20) begin
      n++;
      tick();
    end
    n_run++;
    if (n != 8) begin
      n_fail++;
      $display("FAIL restart_len: got %0d cycles want 8", n);
    end
    src(0, 11, 0);
    tick();
    n_run++;
    if (rs1(0) !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL retire_in_recover: got %h want 100000000", rs1(0));
    end
  endtask

  task automatic test_async_reset();
    clr();
    ren(0, 12, 'h50);
    tick();
    clr();
    rob_flush      = 1'b1;
    rob_ret_valid  = 1'b1;
    rob_ret_rd     = 6'd7;
    rob_ret_result = 32'h66;
    tick();
    clr();
    tick();
    #2;
    rst = 1'b0;
    #1;
    n_run++;
    if ({rat_ready, rat_rs1_valid, rat_rs1_tagval} !== {3'b111, 64'h0}) begin
      n_fail++;
      $display("FAIL async_reset: got %b %b %h want 1 11 0", rat_ready, rat_rs1_valid, rat_rs1_tagval);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    src(0, 7, 12);
    tick();
    n_run++;
    if ({rs1(0), rs2(0)} !== {2{1'b1, 32'h0}}) begin
      n_fail++;
      $display("FAIL post_reset_table: got %h %h want 100000000", rs1(0), rs2(0));
    end
  endtask

  initial begin
    test_reset();
    test_rename_bypass();
    test_wb_fwd();
    test_same_rd();
    test_x0();
    test_back_to_back();
    test_recovery();
    test_flush_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
